// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] RV_NOP           = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t with flush; pointers carry one
// extra wrap bit so full and empty are distinguishable.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           data_i,
    output fetch_entry_t           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   wr_d;
    logic [AW:0]   rd_q;
    logic [AW:0]   rd_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o   = wr_q - rd_q;
    assign data_o    = mem_q[rd_q[AW-1:0]];
    // A push into a full buffer is legal only alongside a pop of the head.
    assign push_ok_s = push_i && (!full_o || pop_i);
    assign pop_ok_s  = pop_i && !empty_o;

    // Pointer next-state; flush empties the buffer and wins over push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            wr_d = push_ok_s ? wr_q + {{AW{1'b0}}, 1'b1} : wr_q;
            rd_d = pop_ok_s  ? rd_q + {{AW{1'b0}}, 1'b1} : rd_q;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push_ok_s && !flush_i) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-based imem requests, response buffering, redirects.
// Optional FETCH_MISALIGN_CHK_EN adds fetch_misaligned and halts on unaligned redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            fetch_misaligned,
`endif
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, target_s;
    logic [CW-1:0]   out_q, out_d, kill_q, kill_d, fifo_count_s, used_s;
    logic            halt_q, halt_d, target_misaligned_s;
    logic            req_fire_s, pop_s, push_s, credit_ok_s;
    logic            fifo_empty_s, fifo_full_s;
    fetch_entry_t    push_entry_s, head_s;

`ifdef FETCH_MISALIGN_CHK_EN
    logic            misal_q;
    assign target_s            = redirect_pc;
    assign target_misaligned_s = |redirect_pc[1:0];
`else
    assign target_s            = redirect_pc & ALIGN_MASK;
    assign target_misaligned_s = 1'b0;
`endif

    // A same-cycle pop returns its slot, which is what sustains one fetch per cycle.
    assign pop_s          = inst_valid && inst_ready && !redirect_valid;
    assign used_s         = out_q + fifo_count_s - {{(CW-1){1'b0}}, pop_s};
    assign credit_ok_s    = (used_s < CW'(FIFO_DEPTH)) && !(fifo_full_s && !pop_s);
    assign imem_req_valid = !rst && credit_ok_s && !redirect_valid && !halt_q;
    assign imem_req_addr  = pc_q;
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign push_s         = imem_rsp_valid && !redirect_valid && (kill_q == '0);
    assign push_entry_s   = '{inst: imem_rsp_data, pc: rsp_pc_q};

    assign inst_valid = !fifo_empty_s;
    assign inst       = head_s.inst;
    assign inst_pc    = head_s.pc;

    // Next-state for PC, response PC, outstanding/kill accounting and halt.
    always_comb begin
        out_d    = out_q + {{(CW-1){1'b0}}, req_fire_s} - {{(CW-1){1'b0}}, imem_rsp_valid};
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        kill_d   = kill_q;
        halt_d   = halt_q;
        if (redirect_valid) begin
            pc_d     = target_s;
            rsp_pc_d = target_s;
            kill_d   = out_d;
            halt_d   = target_misaligned_s;
        end else begin
            pc_d = req_fire_s ? pc_q + 32'd4 : pc_q;
            if (imem_rsp_valid && (kill_q != '0)) begin
                kill_d = kill_q - {{(CW-1){1'b0}}, 1'b1};
            end else if (imem_rsp_valid) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end else begin
                kill_d = kill_q;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            kill_q   <= '0;
            halt_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            kill_q   <= kill_d;
            halt_q   <= halt_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // One-cycle flag for each unaligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            misal_q <= 1'b0;
        end else begin
            misal_q <= redirect_valid && target_misaligned_s;
        end
    end
    assign fetch_misaligned = misal_q;
`endif

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (redirect_valid),
        .data_i  (push_entry_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an in-order latency-programmable imem model.
module tb_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;
    localparam logic [31:0] K     = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misaligned;
`endif

    int errors = 0;
    int checks = 0;
    int pe = 0;
    int lat = 1;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t pend[$];
    ev_t reqs[$];
    ev_t pops[$];

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pe <= pe + 1;

    // Memory model and transaction monitor; pe+1 is the index of the coming posedge.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{pe + 1 + lat, imem_req_addr, 32'h0});
                reqs.push_back('{pe + 1, imem_req_addr, 32'h0});
            end
            if (inst_valid && inst_ready && !redirect_valid)
                pops.push_back('{pe + 1, inst_pc, inst});
            if (pend.size() > 0 && pend[0].cyc == pe + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend[0].a ^ K;
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        step(3);
        reqs.delete();
        pops.delete();
        rst = 1'b0;
    endtask

    task automatic wait_reqs(input int n);
        int budget = 0;
        while (reqs.size() < n && budget < 30) begin
            step();
            budget++;
        end
        checks++;
        if (reqs.size() !== n) begin
            errors++;
            $display("FAIL wait_reqs: got %0d requests, expected %0d", reqs.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks += 4;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst); end
        if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
    endtask

    task automatic test_stream();
        lat = 1;
        inst_ready = 1'b1;
        do_reset();
        step(12);
        checks += 2;
        if (reqs.size() < 8) begin errors++; $display("FAIL stream_req_count: got %0d expected >=8", reqs.size()); end
        if (pops.size() < 6) begin errors++; $display("FAIL stream_pop_count: got %0d expected >=6", pops.size()); end
        for (int i = 0; i < 3 && i < reqs.size(); i++) begin
            checks += 2;
            if (reqs[i].a !== RPC + 32'(4 * i)) begin errors++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, reqs[i].a, RPC + 32'(4 * i)); end
            if (reqs[i].cyc !== reqs[0].cyc + i) begin errors++; $display("FAIL stream_req_cycle[%0d]: got %0d expected %0d", i, reqs[i].cyc, reqs[0].cyc + i); end
        end
        for (int i = 0; i < 6 && i < pops.size(); i++) begin
            checks += 3;
            if (pops[i].a !== RPC + 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, pops[i].a, RPC + 32'(4 * i)); end
            if (pops[i].d !== ((RPC + 32'(4 * i)) ^ K)) begin errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, pops[i].d, (RPC + 32'(4 * i)) ^ K); end
            if (pops[i].cyc !== pops[0].cyc + i) begin errors++; $display("FAIL stream_rate[%0d]: got cycle %0d expected %0d", i, pops[i].cyc, pops[0].cyc + i); end
        end
    endtask

    task automatic test_backpressure();
        lat = 1;
        inst_ready = 1'b0;
        do_reset();
        step(10);
        checks += 5;
        if (reqs.size() !== DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d expected %0d", reqs.size(), DEPTH); end
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_inst_valid: got %b expected 1", inst_valid); end
        if (inst_pc !== RPC) begin errors++; $display("FAIL bp_head_pc: got %h expected %h", inst_pc, RPC); end
        if (inst !== (RPC ^ K)) begin errors++; $display("FAIL bp_head_inst: got %h expected %h", inst, RPC ^ K); end
        inst_ready = 1'b1;
        step(12);
        checks++;
        if (pops.size() < 8) begin errors++; $display("FAIL bp_drain_count: got %0d expected >=8", pops.size()); end
        for (int i = 0; i < 8 && i < pops.size(); i++) begin
            checks += 2;
            if (pops[i].a !== RPC + 32'(4 * i)) begin errors++; $display("FAIL bp_drain_pc[%0d]: got %h expected %h", i, pops[i].a, RPC + 32'(4 * i)); end
            if (pops[i].d !== ((RPC + 32'(4 * i)) ^ K)) begin errors++; $display("FAIL bp_drain_inst[%0d]: got %h expected %h", i, pops[i].d, (RPC + 32'(4 * i)) ^ K); end
        end
    endtask

    task automatic test_redirect_stale();
        lat = 3;
        inst_ready = 1'b1;
        do_reset();
        wait_reqs(2);
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stale_credit: got %b expected 0", imem_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL stale_inst_valid: got %b expected 0", inst_valid); end
        step(20);
        checks++;
        if (pops.size() < 2 || reqs.size() < 4) begin
            errors++;
            $display("FAIL stale_progress: got %0d pops %0d reqs expected >=2 and >=4", pops.size(), reqs.size());
        end else begin
            checks += 4;
            if (reqs[2].a !== 32'h0000_0200) begin errors++; $display("FAIL stale_req0: got %h expected 00000200", reqs[2].a); end
            if (pops[0].a !== 32'h0000_0200) begin errors++; $display("FAIL stale_first_pc: got %h expected 00000200", pops[0].a); end
            if (pops[0].d !== (32'h0000_0200 ^ K)) begin errors++; $display("FAIL stale_first_inst: got %h expected %h", pops[0].d, 32'h0000_0200 ^ K); end
            if (pops[1].a !== 32'h0000_0204) begin errors++; $display("FAIL stale_second_pc: got %h expected 00000204", pops[1].a); end
        end
    endtask

    task automatic test_redirect_collide();
        int np, nr, rc;
        lat = 1;
        inst_ready = 1'b1;
        do_reset();
        step(6);
        checks++;
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL collide_pre_valid: got %b expected 1", inst_valid); end
        np = pops.size();
        nr = reqs.size();
        rc = pe;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0400;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL collide_no_req: got %b expected 0", imem_req_valid); end
        step();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL collide_inst_valid: got %b expected 0", inst_valid); end
        step(8);
        checks++;
        if (pops.size() < np + 2 || reqs.size() < nr + 1) begin
            errors++;
            $display("FAIL collide_progress: got %0d pops %0d reqs", pops.size(), reqs.size());
        end else begin
            checks += 5;
            if (reqs[nr].a !== 32'h0000_0400) begin errors++; $display("FAIL collide_req_addr: got %h expected 00000400", reqs[nr].a); end
            if (reqs[nr].cyc !== rc + 2) begin errors++; $display("FAIL collide_req_cycle: got %0d expected %0d", reqs[nr].cyc, rc + 2); end
            if (pops[np].a !== 32'h0000_0400) begin errors++; $display("FAIL collide_first_pc: got %h expected 00000400", pops[np].a); end
            if (pops[np].d !== (32'h0000_0400 ^ K)) begin errors++; $display("FAIL collide_first_inst: got %h expected %h", pops[np].d, 32'h0000_0400 ^ K); end
            if (pops[np + 1].a !== 32'h0000_0404) begin errors++; $display("FAIL collide_second_pc: got %h expected 00000404", pops[np + 1].a); end
        end
    endtask

    task automatic test_wrap();
        int np, nr;
        lat = 1;
        inst_ready = 1'b1;
        do_reset();
        step(3);
        np = pops.size();
        nr = reqs.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step(8);
        checks++;
        if (pops.size() < np + 2 || reqs.size() < nr + 2) begin
            errors++;
            $display("FAIL wrap_progress: got %0d pops %0d reqs", pops.size(), reqs.size());
        end else begin
            checks += 5;
            if (reqs[nr].a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0: got %h expected fffffffc", reqs[nr].a); end
            if (reqs[nr + 1].a !== 32'h0000_0000) begin errors++; $display("FAIL wrap_req1: got %h expected 00000000", reqs[nr + 1].a); end
            if (pops[np].a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h expected fffffffc", pops[np].a); end
            if (pops[np].d !== 32'h2152_FFFC) begin errors++; $display("FAIL wrap_inst0: got %h expected 2152fffc", pops[np].d); end
            if (pops[np + 1].a !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc1: got %h expected 00000000", pops[np + 1].a); end
        end
    endtask

    task automatic test_back_to_back();
        lat = 3;
        inst_ready = 1'b1;
        do_reset();
        wait_reqs(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0500;
        step();
        redirect_pc = 32'h0000_0600;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_req: got %b expected 0", imem_req_valid); end
        step();
        redirect_valid = 1'b0;
        step(20);
        checks++;
        if (pops.size() < 2 || reqs.size() < 3) begin
            errors++;
            $display("FAIL b2b_progress: got %0d pops %0d reqs", pops.size(), reqs.size());
        end else begin
            checks += 4;
            if (reqs[2].a !== 32'h0000_0600) begin errors++; $display("FAIL b2b_req: got %h expected 00000600", reqs[2].a); end
            if (pops[0].a !== 32'h0000_0600) begin errors++; $display("FAIL b2b_first_pc: got %h expected 00000600", pops[0].a); end
            if (pops[0].d !== (32'h0000_0600 ^ K)) begin errors++; $display("FAIL b2b_first_inst: got %h expected %h", pops[0].d, 32'h0000_0600 ^ K); end
            if (pops[1].a !== 32'h0000_0604) begin errors++; $display("FAIL b2b_second_pc: got %h expected 00000604", pops[1].a); end
        end
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        int np, nr;
        lat = 1;
        inst_ready = 1'b1;
        do_reset();
        step(4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0302;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (fetch_misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", fetch_misaligned); end
        nr = reqs.size();
        np = pops.size();
        step();
        checks++;
        if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b expected 0", fetch_misaligned); end
        step(6);
        checks += 3;
        if (reqs.size() !== nr) begin errors++; $display("FAIL mis_halt_reqs: got %0d expected %0d", reqs.size(), nr); end
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_halt_valid: got %b expected 0", imem_req_valid); end
        if (pops.size() !== np) begin errors++; $display("FAIL mis_halt_pops: got %0d expected %0d", pops.size(), np); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        step(6);
        checks++;
        if (reqs.size() <= nr || pops.size() <= np) begin
            errors++;
            $display("FAIL mis_resume: got %0d reqs %0d pops", reqs.size(), pops.size());
        end else begin
            checks += 2;
            if (reqs[nr].a !== 32'h0000_0300) begin errors++; $display("FAIL mis_resume_req: got %h expected 00000300", reqs[nr].a); end
            if (pops[np].a !== 32'h0000_0300) begin errors++; $display("FAIL mis_resume_pc: got %h expected 00000300", pops[np].a); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_collide();
        test_wrap();
        test_back_to_back();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
